cordic: RTL and testbench
=========================

CORDIC -- requirements
Module: cordic

Interface
REQ-001 SHALL have one clock and an asynchronous active-low reset; no other clocks or resets.
REQ-002 i_clk  input  1  system clock; all state changes on rising edge.
REQ-003 i_rst  input  1  asynchronous active-low reset (0 = reset asserted).
REQ-004 i_start  input  1  start request; sampled on rising i_clk.
REQ-005 i_angle  input  8  signed two's-complement angle in radians, Q2.6 (1.0 = 0x40); valid range -0x64..+0x64 (about -pi/2..+pi/2).
REQ-006 o_sin  output  8  signed Q2.6 sine of the captured angle.
REQ-007 o_cos  output  8  signed Q2.6 cosine of the captured angle.
REQ-008 o_done  output  1  one-cycle pulse; result valid.

Function
REQ-009 SHALL compute sin and cos by rotation-mode CORDIC with 8 micro-rotations, one per clock.
REQ-010 SHALL use states IDLE, BUSY, DONE.
- IDLE: i_start=1 -> BUSY.
- BUSY: 8 cycles, then -> DONE.
- DONE: one cycle -> IDLE; i_start=1 in DONE -> BUSY.
REQ-011 On an accepted start, SHALL capture i_angle into z and initialise x = 1/K (0x27 = 0.607 in Q2.6; internal precision scaled accordingly) and y = 0.
- Later changes to i_angle SHALL NOT affect the result.
REQ-012 Iteration i (0..7): d = +1 if z >= 0, else -1.
- x' = x - d*(y>>>i)
- y' = y + d*(x>>>i)
- z' = z - d*atan(2^-i)
- >>> is arithmetic shift.
REQ-013 Atan table (Q2.6, decimal): 50, 30, 16, 8, 4, 2, 1, 1 (scaled with any extra fractional bits).
REQ-014 Internal x/y/z datapath SHALL carry 4 extra fractional guard bits (12-bit signed).
- Outputs SHALL be rounded to nearest Q2.6.
- Outputs SHALL saturate to 0x7F/0x80; no wrap.
REQ-015 o_done SHALL be high for exactly one cycle, in the cycle after the 9th rising edge following the start-sampling edge.
- Latency = 9 cycles.
REQ-016 o_sin/o_cos SHALL update only on the edge that asserts o_done.
- They SHALL then hold until the next result, including while BUSY.
REQ-017 i_start while BUSY SHALL be ignored; the computation SHALL not restart.
REQ-018 Accuracy for angles in the valid range: |error| <= 2 LSB against round(64*sin) and round(64*cos).
REQ-019 Angles outside the valid range SHALL complete normally with the same latency; result values are unspecified.

Reset
REQ-020 Asserting i_rst (low), at any time including mid-computation, SHALL immediately force:
- state IDLE
- o_done = 0
- o_sin = 0x00, o_cos = 0x00
- all internal registers cleared
REQ-021 After i_rst deasserts, the first i_start SHALL be accepted on the next rising edge with full 9-cycle latency.

Verification
REQ-022 angle 0x00, start pulse -> o_done after 9 cycles; cos 0x40 +/-2, sin 0x00 +/-2.
REQ-023 angle 0x32 -> sin and cos each 0x2D +/-2.
REQ-024 angle 0x64 -> sin 0x40 +/-2, cos 0x00 +/-2; angle 0xCE (-50) -> sin 0xD3 +/-2, cos 0x2D +/-2.
REQ-025 Sweep angles 0x00..0x64, one start per result: every result within +/-2 LSB, exactly one o_done per start, outputs stable between results.
REQ-026 Pulse i_start again 3 cycles into BUSY -> ignored; single o_done at cycle 9 with the original angle's result.
REQ-027 Drive i_rst low at cycle 4 of BUSY -> outputs 0x00/0x00, no o_done; a new start after release gives the correct result after 9 cycles.

Source files
------------

// File: rtl/cordic_if.sv
`default_nettype none
// ============================================================================
// Module   : cordic_if
// Brief    : Start/angle request and sin/cos result bundle for the CORDIC core
// Revision : 1.0
// ============================================================================
interface cordic_if;
    logic       i_start;
    logic [7:0] i_angle;
    logic [7:0] o_sin;
    logic [7:0] o_cos;
    logic       o_done;

    modport master (
        output i_start,
        output i_angle,
        input  o_sin,
        input  o_cos,
        input  o_done
    );

    modport slave (
        input  i_start,
        input  i_angle,
        output o_sin,
        output o_cos,
        output o_done
    );
endinterface
`default_nettype wire

// File: rtl/cordic.sv
`default_nettype none
// ============================================================================
// Module   : cordic
// Brief    : Rotation-mode CORDIC, 8 micro-rotations, Q2.6 sin/cos outputs
// Revision : 1.0
// ============================================================================
module cordic (
    input  logic    i_clk,
    input  logic    i_rst,
    cordic_if.slave bus
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    // 1/K in Q2.10 (0.60725 * 1024)
    localparam logic signed [11:0] c_inv_k = 12'sd622;

    logic [1:0]         r_state;
    logic [1:0]         w_next;
    logic [2:0]         r_iter;
    logic signed [11:0] r_x;
    logic signed [11:0] r_y;
    logic signed [11:0] r_z;
    logic signed [7:0]  r_sin;
    logic signed [7:0]  r_cos;
    logic               r_done;

    logic               w_load;
    logic               w_step;
    logic               w_finish;
    logic signed [11:0] w_atan;
    logic signed [11:0] w_xs;
    logic signed [11:0] w_ys;

    function automatic logic signed [7:0] round_sat(input logic signed [11:0] v);
        logic signed [12:0] s;
        s = $signed({v[11], v}) + 13'sd8;
        s = s >>> 4;
        if (s > 13'sd127)
            return 8'sh7f;
        else if (s < -13'sd128)
            return 8'sh80;
        return s[7:0];
    endfunction

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  w_next = bus.i_start ? S_BUSY : S_IDLE;
            S_BUSY:  w_next = (r_iter == 3'd7) ? S_DONE : S_BUSY;
            S_DONE:  w_next = bus.i_start ? S_BUSY : S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // DONE is the rounding cycle; the result and o_done register on its exit edge
    always_comb begin
        w_load   = 1'b0;
        w_step   = 1'b0;
        w_finish = 1'b0;
        case (r_state)
            S_IDLE:  w_load = bus.i_start;
            S_BUSY:  w_step = 1'b1;
            S_DONE: begin
                w_finish = 1'b1;
                w_load   = bus.i_start;
            end
            default: ;
        endcase
    end

    // atan(2^-i) rounded to Q2.10
    always_comb begin
        w_atan = 12'sd0;
        case (r_iter)
            3'd0:    w_atan = 12'sd804;
            3'd1:    w_atan = 12'sd475;
            3'd2:    w_atan = 12'sd251;
            3'd3:    w_atan = 12'sd127;
            3'd4:    w_atan = 12'sd64;
            3'd5:    w_atan = 12'sd32;
            3'd6:    w_atan = 12'sd16;
            3'd7:    w_atan = 12'sd8;
            default: w_atan = 12'sd0;
        endcase
    end

    assign w_xs = r_x >>> r_iter;
    assign w_ys = r_y >>> r_iter;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_x    <= 12'sd0;
            r_y    <= 12'sd0;
            r_z    <= 12'sd0;
            r_iter <= 3'd0;
        end else if (w_load) begin
            r_x    <= c_inv_k;
            r_y    <= 12'sd0;
            r_z    <= $signed({bus.i_angle, 4'b0000});
            r_iter <= 3'd0;
        end else if (w_step) begin
            if (!r_z[11]) begin
                r_x <= r_x - w_ys;
                r_y <= r_y + w_xs;
                r_z <= r_z - w_atan;
            end else begin
                r_x <= r_x + w_ys;
                r_y <= r_y - w_xs;
                r_z <= r_z + w_atan;
            end
            r_iter <= r_iter + 3'd1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_sin  <= 8'sd0;
            r_cos  <= 8'sd0;
            r_done <= 1'b0;
        end else begin
            r_done <= w_finish;
            if (w_finish) begin
                r_sin <= round_sat(r_y);
                r_cos <= round_sat(r_x);
            end
        end
    end

    assign bus.o_sin  = r_sin;
    assign bus.o_cos  = r_cos;
    assign bus.o_done = r_done;

endmodule
`default_nettype wire

// File: tb/tb_cordic.sv
`default_nettype none
// ============================================================================
// Module   : tb_cordic
// Brief    : Directed-vector self-checking bench for the CORDIC core
// Revision : 1.0
// ============================================================================
module tb_cordic;

    logic i_clk = 1'b0;
    logic i_rst = 1'b0;

    cordic_if bus ();

    cordic dut (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .bus   (bus)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [7:0] angle;
        int         sin_e;
        int         cos_e;
    } vec_t;

    vec_t vecs [11];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic check_int(input string name, input int act, input int exp, input int tol);
        n_vec++;
        if (act - exp > tol || exp - act > tol) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (tol %0d)", name, act, exp, tol);
        end
    endtask

    function automatic int round_r(input real v);
        if (v >= 0.0)
            return $rtoi(v + 0.5);
        return -$rtoi(-v + 0.5);
    endfunction

    // One start, then scramble the angle input and watch latency, stability and pulse width
    task automatic run_one(input logic [7:0] ang, input string tag, input int exp_s, input int exp_c);
        logic [7:0] hs;
        logic [7:0] hc;
        int         k;
        int         stable;
        hs     = bus.o_sin;
        hc     = bus.o_cos;
        stable = 1;
        bus.i_angle = ang;
        bus.i_start = 1'b1;
        tick();
        bus.i_start = 1'b0;
        bus.i_angle = 8'($urandom);
        k = 0;
        while (!bus.o_done && k < 30) begin
            if (bus.o_sin !== hs || bus.o_cos !== hc)
                stable = 0;
            tick();
            k++;
        end
        check_int({tag, " latency"}, k, 9, 0);
        check_int({tag, " sin"}, $signed(bus.o_sin), exp_s, 2);
        check_int({tag, " cos"}, $signed(bus.o_cos), exp_c, 2);
        check_int({tag, " stable"}, stable, 1, 0);
        tick();
        check_int({tag, " done width"}, int'(bus.o_done), 0, 0);
    endtask

    initial begin
        int ndone;
        int first_t;
        int second_t;
        int s_at;
        int c_at;

        vecs[0]  = '{8'h00,   0,  64};
        vecs[1]  = '{8'h32,  45,  45};
        vecs[2]  = '{8'h64,  64,   1};
        vecs[3]  = '{8'hCE, -45,  45};
        vecs[4]  = '{8'h20,  31,  56};
        vecs[5]  = '{8'hE0, -31,  56};
        vecs[6]  = '{8'h40,  54,  35};
        vecs[7]  = '{8'h10,  16,  62};
        vecs[8]  = '{8'h9C, -64,   1};
        vecs[9]  = '{8'h08,   8,  64};
        vecs[10] = '{8'h58,  63,  12};

        bus.i_start = 1'b0;
        bus.i_angle = 8'h00;
        #2;
        check_int("reset sin", int'(bus.o_sin), 0, 0);
        check_int("reset cos", int'(bus.o_cos), 0, 0);
        check_int("reset done", int'(bus.o_done), 0, 0);
        tick();
        i_rst = 1'b1;
        tick();

        for (int i = 0; i < 11; i++)
            run_one(vecs[i].angle, $sformatf("vec%0d", i), vecs[i].sin_e, vecs[i].cos_e);

        for (int a = 0; a <= 100; a++)
            run_one(8'(a), $sformatf("sweep%0d", a),
                    round_r(64.0 * $sin(a / 64.0)), round_r(64.0 * $cos(a / 64.0)));

        // Second start three cycles into BUSY must be ignored
        bus.i_angle = 8'h20;
        bus.i_start = 1'b1;
        tick();
        bus.i_start = 1'b0;
        tick(); tick(); tick();
        bus.i_angle = 8'h40;
        bus.i_start = 1'b1;
        tick();
        bus.i_start = 1'b0;
        ndone = 0; first_t = 0; s_at = 0; c_at = 0;
        for (int t = 5; t <= 25; t++) begin
            tick();
            if (bus.o_done) begin
                ndone++;
                if (first_t == 0) begin
                    first_t = t;
                    s_at    = $signed(bus.o_sin);
                    c_at    = $signed(bus.o_cos);
                end
            end
        end
        check_int("ignore start done count", ndone, 1, 0);
        check_int("ignore start latency", first_t, 9, 0);
        check_int("ignore start sin", s_at, 31, 2);
        check_int("ignore start cos", c_at, 56, 2);

        // Start held high: restarts from DONE, so pulses land 9 cycles apart
        bus.i_angle = 8'h10;
        bus.i_start = 1'b1;
        tick();
        ndone = 0; first_t = 0; second_t = 0; s_at = 0;
        for (int t = 1; t <= 20; t++) begin
            tick();
            if (bus.o_done) begin
                ndone++;
                if (first_t == 0) begin
                    first_t = t;
                    s_at    = $signed(bus.o_sin);
                end else if (second_t == 0) begin
                    second_t = t;
                end
            end
        end
        bus.i_start = 1'b0;
        check_int("held start done count", ndone, 2, 0);
        check_int("held start first", first_t, 9, 0);
        check_int("held start second", second_t, 18, 0);
        check_int("held start sin", s_at, 16, 2);
        repeat (15) tick();

        // Reset asserted four cycles into BUSY
        bus.i_angle = 8'h40;
        bus.i_start = 1'b1;
        tick();
        bus.i_start = 1'b0;
        repeat (4) tick();
        #2;
        i_rst = 1'b0;
        #1;
        check_int("midreset sin", int'(bus.o_sin), 0, 0);
        check_int("midreset cos", int'(bus.o_cos), 0, 0);
        check_int("midreset done", int'(bus.o_done), 0, 0);
        ndone = 0;
        for (int t = 0; t < 12; t++) begin
            tick();
            if (bus.o_done)
                ndone++;
        end
        check_int("midreset no done", ndone, 0, 0);
        i_rst = 1'b1;
        run_one(8'h32, "after reset", 45, 45);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
